// File: rtl/serial_tx_arbiter_if.sv
// Request/grant and serial-output bundle for serial_tx_arbiter.
// master = requester side (drives req/data), slave = the arbiter.
interface serial_tx_arbiter_if #(
  parameter int SIZE = 8,
  parameter int NREQ = 4
);
  localparam int IW = $clog2(NREQ);

  // Handshake: req[i] is a level request that the requester holds until gnt[i]
  // pulses for one cycle; data[i*SIZE +: SIZE] is captured on that same edge.
  // ser_out is meaningful only while ser_valid is high.
  logic [NREQ-1:0]      req;
  logic [NREQ*SIZE-1:0] data;
  logic [NREQ-1:0]      gnt;
  logic                 ser_out;
  logic                 ser_valid;
  logic                 busy;
  logic                 done;
  logic [IW-1:0]        done_id;

  modport master (
    output req, data,
    input  gnt, ser_out, ser_valid, busy, done, done_id
  );

  modport slave (
    input  req, data,
    output gnt, ser_out, ser_valid, busy, done, done_id
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter feeding a serializer: grants one requester, then shifts its word out.
// Define SERIAL_TX_ARBITER_PARITY_EN to append an even-parity bit to each frame.
module serial_tx_arbiter #(
  parameter int SIZE      = 8,
  parameter int NREQ      = 4,
  parameter int SHIFT_DIR = 0
) (
  input  logic               clk,
  input  logic               reset,
  serial_tx_arbiter_if.slave bus,
  output logic               state_dbg
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(SIZE + 1);
  localparam int SW = $clog2(SIZE);
`ifdef SERIAL_TX_ARBITER_PARITY_EN
  localparam int FLEN = SIZE + 1;
`else
  localparam int FLEN = SIZE;
`endif
  localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic [SIZE-1:0] shadow;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   bit_idx;
  logic            frame_bit;
  int              cand;

  assign state_dbg = (state == SHIFT);

  // First asserted request at or above rr_ptr, wrapping past NREQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && bus.req[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    if (SHIFT_DIR == 0) bit_idx = SW'(cnt);
    else                bit_idx = SW'(SIZE - 1) - SW'(cnt);
`ifdef SERIAL_TX_ARBITER_PARITY_EN
    frame_bit = (cnt == CW'(SIZE)) ? ^shadow : shadow[bit_idx];
`else
    frame_bit = shadow[bit_idx];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      shadow        <= '0;
      cnt           <= '0;
      bus.gnt       <= '0;
      bus.ser_out   <= 1'b0;
      bus.ser_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.done_id   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.ser_out   <= 1'b0;
          bus.ser_valid <= 1'b0;
          bus.done      <= 1'b0;
          cnt           <= '0;
          if (win_found) begin
            bus.gnt     <= NREQ'(1) << win_idx;
            shadow      <= bus.data[win_idx*SIZE +: SIZE];
            bus.done_id <= win_idx;
            bus.busy    <= 1'b1;
            rr_ptr      <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            state       <= SHIFT;
          end else begin
            bus.gnt  <= '0;
            bus.busy <= 1'b0;
          end
        end
        SHIFT: begin
          bus.gnt       <= '0;
          bus.ser_out   <= frame_bit;
          bus.ser_valid <= 1'b1;
          // busy stays high through the last bit; it drops on the next IDLE edge.
          if (cnt == LAST) begin
            bus.done <= 1'b1;
            cnt      <= '0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: LSB-first and MSB-first instances driven with the same
// stimulus and compared cycle by cycle against a queue-based frame model.
module tb_serial_tx_arbiter;
  localparam int SIZE = 8;
  localparam int NREQ = 4;
  localparam int IW   = $clog2(NREQ);

  logic clk = 1'b0;
  logic reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*SIZE-1:0] data;
  logic st0, st1;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic q0[$];
  logic q1[$];
  int   m_ptr;
  int   e_id;
  logic [NREQ-1:0] e_gnt;
  logic e_ser0, e_ser1, e_valid, e_busy, e_done, e_shift;
  logic auto_drop;

  // observation helpers
  logic [SIZE-1:0] cap0, cap1;
  int   cap_n0, cap_n1;
  int   dut_dones;
  logic [NREQ-1:0] g_obs[$];

  always #5 clk = ~clk;

  serial_tx_arbiter_if #(.SIZE(SIZE), .NREQ(NREQ)) bus0 ();
  serial_tx_arbiter_if #(.SIZE(SIZE), .NREQ(NREQ)) bus1 ();

  assign bus0.req  = req;
  assign bus0.data = data;
  assign bus1.req  = req;
  assign bus1.data = data;

  serial_tx_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .SHIFT_DIR(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .state_dbg(st0));
  serial_tx_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .SHIFT_DIR(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .state_dbg(st1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_dut(input string d, input logic [NREQ-1:0] gnt, input logic ser,
                           input logic valid, input logic busy, input logic done,
                           input logic [IW-1:0] id, input logic st, input logic exp_ser);
    check({d, ".gnt"},       32'(gnt),   32'(e_gnt));
    check({d, ".ser_out"},   32'(ser),   32'(exp_ser));
    check({d, ".ser_valid"}, 32'(valid), 32'(e_valid));
    check({d, ".busy"},      32'(busy),  32'(e_busy));
    check({d, ".done"},      32'(done),  32'(e_done));
    check({d, ".state"},     32'(st),    32'(e_shift));
    if (e_busy || e_done) check({d, ".done_id"}, 32'(id), 32'(e_id));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".d0.gnt"},     32'(bus0.gnt),       32'd0);
    check({tag, ".d0.ser_out"}, 32'(bus0.ser_out),   32'd0);
    check({tag, ".d0.valid"},   32'(bus0.ser_valid), 32'd0);
    check({tag, ".d0.busy"},    32'(bus0.busy),      32'd0);
    check({tag, ".d0.done"},    32'(bus0.done),      32'd0);
    check({tag, ".d0.done_id"}, 32'(bus0.done_id),   32'd0);
    check({tag, ".d0.state"},   32'(st0),            32'd0);
    check({tag, ".d1.gnt"},     32'(bus1.gnt),       32'd0);
    check({tag, ".d1.valid"},   32'(bus1.ser_valid), 32'd0);
    check({tag, ".d1.busy"},    32'(bus1.busy),      32'd0);
    check({tag, ".d1.done"},    32'(bus1.done),      32'd0);
    check({tag, ".d1.state"},   32'(st1),            32'd0);
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_ptr = 0;
    e_id  = 0;
  endtask

  // Reset pulse issued away from the rising edge, released on the falling edge.
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    check_reset(tag);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_capture();
    cap0 = '0; cap1 = '0; cap_n0 = 0; cap_n1 = 0;
  endtask

  // One clock: predict what the coming edge does, take the edge, compare.
  task automatic step();
    int w;
    logic [SIZE-1:0] wd;
    w = -1;
    if (q0.size() == 0) begin
      e_valid = 1'b0; e_ser0 = 1'b0; e_ser1 = 1'b0; e_done = 1'b0;
      e_gnt   = '0;
      if (req != '0) begin
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        e_gnt[w] = 1'b1;
        e_id  = w;
        m_ptr = (w + 1) % NREQ;
        wd = data[w*SIZE +: SIZE];
        for (int k = 0; k < SIZE; k++) begin
          q0.push_back(wd[k]);
          q1.push_back(wd[SIZE-1-k]);
        end
`ifdef SERIAL_TX_ARBITER_PARITY_EN
        q0.push_back(^wd);
        q1.push_back(^wd);
`endif
        e_busy = 1'b1;
      end else begin
        e_busy = 1'b0;
      end
    end else begin
      e_gnt   = '0;
      e_ser0  = q0.pop_front();
      e_ser1  = q1.pop_front();
      e_valid = 1'b1;
      e_busy  = 1'b1;
      e_done  = (q0.size() == 0);
    end
    e_shift = (q0.size() != 0);
    @(posedge clk);
    #1;
    check_dut("d0", bus0.gnt, bus0.ser_out, bus0.ser_valid, bus0.busy, bus0.done,
              bus0.done_id, st0, e_ser0);
    check_dut("d1", bus1.gnt, bus1.ser_out, bus1.ser_valid, bus1.busy, bus1.done,
              bus1.done_id, st1, e_ser1);
    if (bus0.ser_valid && cap_n0 < SIZE) begin cap0[cap_n0] = bus0.ser_out; cap_n0++; end
    if (bus1.ser_valid && cap_n1 < SIZE) begin cap1[SIZE-1-cap_n1] = bus1.ser_out; cap_n1++; end
    if (bus0.done) dut_dones++;
    if (bus0.gnt != '0) g_obs.push_back(bus0.gnt);
    if (auto_drop) req = req & ~e_gnt;
  endtask

  task automatic run_until_idle(input string tag);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 80 && !idle; i++) begin
      step();
      if (q0.size() == 0 && !e_busy && req == '0) idle = 1'b1;
    end
    check({tag, ".reached_idle"}, 32'(idle), 32'd1);
  endtask

  initial begin
    logic [NREQ-1:0] g_exp[5];
    reset = 1'b1; req = '0; data = '0; auto_drop = 1'b1;
    dut_dones = 0;
    clear_capture();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    reset = 1'b0;
    step();
    step();

    // single LSB-first request, first grant after reset
    data[0 +: SIZE] = 8'hA5;
    req = 4'b0001;
    clear_capture();
    run_until_idle("single");
    check("single.frame_lsb", 32'(cap0), 32'h0000_00A5);

    // MSB-first on requester 2
    data[2*SIZE +: SIZE] = 8'h81;
    req = 4'b0100;
    clear_capture();
    run_until_idle("msb");
    check("msb.frame_msb", 32'(cap1), 32'h0000_0081);
    check("msb.frame_lsb", 32'(cap0), 32'h0000_0081);

    // contention: all four held high for five grants
    pulse_reset("pre_contention");
    auto_drop = 1'b0;
    for (int i = 0; i < NREQ; i++) data[i*SIZE +: SIZE] = SIZE'($urandom);
    req = 4'b1111;
    dut_dones = 0;
    g_obs.delete();
    for (int i = 0; i < 100 && g_obs.size() < 5; i++) step();
    req = '0;
    auto_drop = 1'b1;
    run_until_idle("contention");
    check("contention.done_pulses", 32'(dut_dones), 32'd5);
    check("contention.grant_count", 32'(g_obs.size()), 32'd5);
    g_exp[0] = 4'b0001; g_exp[1] = 4'b0010; g_exp[2] = 4'b0100;
    g_exp[3] = 4'b1000; g_exp[4] = 4'b0001;
    for (int i = 0; i < 5 && i < g_obs.size(); i++)
      check($sformatf("contention.grant%0d", i), 32'(g_obs[i]), 32'(g_exp[i]));

    // reset after the third bit of a frame
    data[0 +: SIZE] = 8'hA5;
    req = 4'b0001;
    repeat (4) step();
    dut_dones = 0;
    pulse_reset("midframe");
    data[1*SIZE +: SIZE] = SIZE'($urandom);
    req = 4'b0010;
    run_until_idle("after_reset");
    check("after_reset.done_pulses", 32'(dut_dones), 32'd1);

    // data changed mid-frame must not disturb the frame
    data[0 +: SIZE] = 8'hA5;
    req = 4'b0001;
    clear_capture();
    repeat (3) step();
    data[0 +: SIZE] = 8'h00;
    run_until_idle("stability");
    check("stability.frame", 32'(cap0), 32'h0000_00A5);

    // request withdrawn while another frame is in flight
    data[1*SIZE +: SIZE] = SIZE'($urandom);
    req = 4'b0010;
    repeat (3) step();
    req[3] = 1'b1;
    repeat (2) step();
    req[3] = 1'b0;
    run_until_idle("withdrawn");

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 7) == 0) req[i] = 1'b1;
        else if (req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b0;
        if ($urandom_range(0, 3) == 0) data[i*SIZE +: SIZE] = SIZE'($urandom);
      end
      step();
    end
    req = '0;
    run_until_idle("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
